// File: rtl/ospi_target.sv
// ospi_target: octal-SPI memory target (WRITE 0xA0, READ 0x20, optional STATUS 0x05 under OSPI_STATUS_EN).
// Latency: write bytes commit on their sampling edge; read data follows DMY_LEN dummy cycles.
// Backpressure: none, the host owns the clock; ncs=1 on any edge abandons the transfer.
module ospi_target #(
    parameter int ADDR_BYTES = 3,
    parameter int DMY_LEN    = 2,
    parameter int MEM_AW     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ncs,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       data_oe,
    output logic       dqs_o,
    output logic       dqs_oe,
    output logic       xfer_done,
    output logic       cmd_err
);
    localparam logic [7:0] CMD_WRITE = 8'hA0;
    localparam logic [7:0] CMD_READ  = 8'h20;

    typedef enum logic [2:0] {IDLE, HDR, DUMMY, WDATA, RDATA, DONE, IGNORE} state_t;

    state_t            state;
    logic [7:0]        cmd;
    logic [7:0]        len;
    logic [7:0]        cnt;
    logic [2:0]        hcnt;
    logic [3:0]        dcnt;
    logic [MEM_AW-1:0] ptr;
    logic              data_oe_r;
    logic              dqs_oe_r;
    logic [7:0]        rd_byte;
    logic              is_read_cmd;
    logic [7:0]        mem [2**MEM_AW];

`ifdef OSPI_STATUS_EN
    localparam logic [7:0] CMD_STATUS = 8'h05;
    logic err_sticky;

    assign is_read_cmd = (cmd == CMD_READ) || (cmd == CMD_STATUS);
    assign rd_byte     = (cmd == CMD_STATUS) ? {7'b0, err_sticky} : mem[ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            err_sticky <= 1'b0;
        end else if (cmd_err) begin
            err_sticky <= 1'b1;
        end else if (xfer_done && cmd == CMD_STATUS) begin
            err_sticky <= 1'b0;
        end
    end
`else
    assign is_read_cmd = (cmd == CMD_READ);
    assign rd_byte     = mem[ptr];
`endif

    // The bus must let go the same cycle ncs rises, so the enables are not purely registered.
    assign data_oe = data_oe_r & ~ncs;
    assign dqs_oe  = dqs_oe_r & ~ncs;
    assign dqs_o   = dqs_oe & ~clk;

    always_ff @(posedge clk) begin
        if (!reset && !ncs && state == WDATA) begin
            mem[ptr] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cmd       <= '0;
            len       <= '0;
            cnt       <= '0;
            hcnt      <= '0;
            dcnt      <= '0;
            ptr       <= '0;
            data_o    <= '0;
            data_oe_r <= 1'b0;
            dqs_oe_r  <= 1'b0;
            xfer_done <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            xfer_done <= 1'b0;
            cmd_err   <= 1'b0;
            if (ncs) begin
                state     <= IDLE;
                data_oe_r <= 1'b0;
                dqs_oe_r  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cmd   <= data_i;
                        hcnt  <= '0;
                        cnt   <= '0;
                        dcnt  <= '0;
                        state <= HDR;
                    end
                    HDR: begin
                        // ptr doubles as the address shift register; only the low MEM_AW bits survive.
                        if (hcnt == 3'd0) begin
                            len <= data_i;
                        end else begin
                            ptr <= MEM_AW'({ptr, data_i});
                        end
                        hcnt <= hcnt + 3'd1;
                        if (hcnt == 3'(ADDR_BYTES)) begin
                            if (cmd == CMD_WRITE) begin
                                state <= WDATA;
                            end else if (is_read_cmd) begin
                                state    <= DUMMY;
                                dqs_oe_r <= 1'b1;
                            end else begin
                                state   <= IGNORE;
                                cmd_err <= 1'b1;
                            end
                        end
                    end
                    DUMMY: begin
                        if (dcnt == 4'(DMY_LEN - 1)) begin
                            data_o    <= rd_byte;
                            ptr       <= ptr + MEM_AW'(1);
                            data_oe_r <= 1'b1;
                            state     <= RDATA;
                        end else begin
                            dcnt <= dcnt + 4'd1;
                        end
                    end
                    WDATA: begin
                        ptr <= ptr + MEM_AW'(1);
                        cnt <= cnt + 8'd1;
                        if (cnt == len) begin
                            xfer_done <= 1'b1;
                            state     <= DONE;
                        end
                    end
                    RDATA: begin
                        if (cnt == len) begin
                            xfer_done <= 1'b1;
                            state     <= DONE;
                        end else begin
                            data_o <= rd_byte;
                            ptr    <= ptr + MEM_AW'(1);
                            cnt    <= cnt + 8'd1;
                        end
                    end
                    DONE, IGNORE: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ospi_target.sv
// Bench for ospi_target: directed table, reset corner sequences, and random transactions
// checked against a byte-array memory model and a per-cycle timeline derived from the protocol.
module tb_ospi_target;
    localparam int AB  = 3;
    localparam int DMY = 2;
    localparam int H   = 2 + AB;
`ifdef OSPI_STATUS_EN
    localparam bit STATUS_EN = 1'b1;
`else
    localparam bit STATUS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       ncs;
    logic [7:0] data_i;
    logic [7:0] data_o;
    logic       data_oe;
    logic       dqs_o;
    logic       dqs_oe;
    logic       xfer_done;
    logic       cmd_err;

    always #5 clk = ~clk;

    ospi_target #(.ADDR_BYTES(AB), .DMY_LEN(DMY), .MEM_AW(8)) dut (
        .clk(clk), .reset(reset), .ncs(ncs), .data_i(data_i), .data_o(data_o),
        .data_oe(data_oe), .dqs_o(dqs_o), .dqs_oe(dqs_oe),
        .xfer_done(xfer_done), .cmd_err(cmd_err)
    );

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  len;
        logic [31:0] addr;
        logic [31:0] wd;
        int          cut;
        int          exp_done;
        int          exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] ref_mem [256];
    logic       ref_sticky = 1'b0;
    logic [7:0] tr_d    [1024];
    logic       tr_oe   [1024];
    logic       tr_dqs  [1024];
    logic       tr_dqsh [1024];
    logic       tr_dqsl [1024];
    logic       tr_done [1024];
    logic       tr_err  [1024];
    logic [7:0] got_q [$];
    int         last_ndone;
    int         last_nerr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic n, input logic [7:0] d);
        ncs    = n;
        data_i = d;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [7:0] bytes[$], input int edges);
        for (int k = 0; k < edges; k++) begin
            drive(1'b0, (k < bytes.size()) ? bytes[k] : 8'($urandom));
            tr_d[k]    = data_o;
            tr_oe[k]   = data_oe;
            tr_dqs[k]  = dqs_oe;
            tr_done[k] = xfer_done;
            tr_err[k]  = cmd_err;
            tr_dqsh[k] = dqs_o;
            @(negedge clk);
            #1;
            tr_dqsl[k] = dqs_o;
        end
        ncs = 1'b1;
        #1;
        chk("bus_release", 32'({data_oe, dqs_oe}), 32'd0);
        drive(1'b1, 8'h00);
        chk("idle_pulses", 32'({xfer_done, cmd_err, data_oe}), 32'd0);
    endtask

    // kind: 0 write, 1 read/status, 2 unknown command
    task automatic op(input string tag, input logic [7:0] cmd, input logic [7:0] len,
                      input logic [31:0] addr, input logic [7:0] pl[$], input int cut);
        int n, kind, edges, base, epos, m, idx;
        logic e_oe, e_dqs, e_done;
        logic [7:0] bytes[$];
        logic [7:0] exp[$];
        n    = int'(len) + 1;
        kind = (cmd == 8'hA0) ? 0 : ((cmd == 8'h20) || (STATUS_EN && cmd == 8'h05)) ? 1 : 2;
        bytes.push_back(cmd);
        bytes.push_back(len);
        for (int b = AB - 1; b >= 0; b--) bytes.push_back(addr[8*b +: 8]);
        if (kind != 1) foreach (pl[i]) bytes.push_back(pl[i]);
        for (int i = 0; i < n; i++)
            exp.push_back((cmd == 8'h05) ? {7'b0, ref_sticky} : ref_mem[addr[7:0] + 8'(i)]);
        m     = (cut < 0) ? n : cut;
        edges = (kind == 0) ? H + m : (kind == 1) ? H + DMY + n + 2 : H + pl.size() + 1;
        base  = H - 1 + DMY;
        run(bytes, edges);
        got_q.delete();
        last_ndone = 0;
        last_nerr  = 0;
        epos       = -1;
        for (int k = 0; k < edges; k++) begin
            e_oe   = (kind == 1) && (k >= base);
            e_dqs  = (kind == 1) && (k >= H - 1);
            e_done = (kind == 1) ? (k == base + n) : (kind == 0) ? (k == H + n - 1) : 1'b0;
            if (tr_done[k]) last_ndone++;
            if (tr_err[k]) begin
                last_nerr++;
                epos = k;
            end
            chk($sformatf("%s_ctl@%0d", tag, k),
                32'({tr_oe[k], tr_dqs[k], tr_dqsl[k], tr_dqsh[k], tr_done[k]}),
                32'({e_oe, e_dqs, e_dqs, 1'b0, e_done}));
            if (e_oe) begin
                idx = (k - base < n) ? k - base : n - 1;
                chk($sformatf("%s_data@%0d", tag, k), 32'(tr_d[k]), 32'(exp[idx]));
                if (k - base < n) got_q.push_back(tr_d[k]);
            end
        end
        chk({tag, "_err_cnt"}, 32'(last_nerr), (kind == 2) ? 32'd1 : 32'd0);
        if (kind == 2) chk({tag, "_err_pos"}, 32'(epos <= H - 1), 32'd1);
        if (kind == 0) for (int i = 0; i < m; i++) ref_mem[addr[7:0] + 8'(i)] = pl[i];
        if (kind == 1 && cmd == 8'h05) ref_sticky = 1'b0;
        if (kind == 2) ref_sticky = 1'b1;
    endtask

    initial begin
        vec_t       tbl [12];
        logic [7:0] pl [$];
        logic [7:0] hs [$];

        reset  = 1'b1;
        ncs    = 1'b1;
        data_i = 8'h00;
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h00);
        drive(1'b0, 8'hA0);
        drive(1'b0, 8'h20);
        chk("reset_state", 32'({data_o, data_oe, dqs_oe, dqs_o, xfer_done, cmd_err}), 32'd0);
        @(negedge clk);
        #1;
        chk("reset_dqs_low_phase", 32'({dqs_o, dqs_oe}), 32'd0);
        reset = 1'b0;
        drive(1'b1, 8'h00);

        // Known background pattern mem[a] = a ^ 0x5A via one maximum-length write.
        pl.delete();
        for (int a = 0; a < 256; a++) pl.push_back(8'(a) ^ 8'h5A);
        op("init_wr", 8'hA0, 8'hFF, 32'h0, pl, -1);
        pl.delete();
        op("init_rd", 8'h20, 8'hFF, 32'h0, pl, -1);

        tbl[0]  = '{8'hA0, 8'h03, 32'h000010, 32'h11223344, -1, 1, 0, 32'h0};
        tbl[1]  = '{8'h20, 8'h03, 32'h000010, 32'h0,        -1, 1, 0, 32'h11223344};
        tbl[2]  = '{8'hA0, 8'h01, 32'h0000FF, 32'hAABB0000, -1, 1, 0, 32'h0};
        tbl[3]  = '{8'h20, 8'h01, 32'h0000FF, 32'h0,        -1, 1, 0, 32'hAABB0000};
        tbl[4]  = '{8'h20, 8'h00, 32'h000000, 32'h0,        -1, 1, 0, 32'hBB000000};
        tbl[5]  = '{8'h7E, 8'h03, 32'h000010, 32'h55667788, -1, 0, 1, 32'h0};
        tbl[6]  = '{8'h20, 8'h03, 32'h000010, 32'h0,        -1, 1, 0, 32'h11223344};
        tbl[7]  = '{8'hA0, 8'h03, 32'h000020, 32'h99887766,  2, 0, 0, 32'h0};
        tbl[8]  = '{8'h20, 8'h03, 32'h000020, 32'h0,        -1, 1, 0, 32'h99887879};
        if (STATUS_EN) begin
            tbl[9]  = '{8'h05, 8'h00, 32'h000000, 32'h0, -1, 1, 0, 32'h01000000};
            tbl[10] = '{8'h05, 8'h00, 32'h000000, 32'h0, -1, 1, 0, 32'h00000000};
        end else begin
            tbl[9]  = '{8'h05, 8'h00, 32'h000000, 32'h0, -1, 0, 1, 32'h0};
            tbl[10] = '{8'h05, 8'h00, 32'h000000, 32'h0, -1, 0, 1, 32'h0};
        end
        tbl[11] = '{8'h20, 8'h00, 32'hABCD10, 32'h0, -1, 1, 0, 32'h11000000};

        for (int r = 0; r < 12; r++) begin
            pl.delete();
            for (int i = 0; i < 4; i++) pl.push_back(tbl[r].wd[31-8*i -: 8]);
            op($sformatf("row%0d", r), tbl[r].cmd, tbl[r].len, tbl[r].addr, pl, tbl[r].cut);
            chk($sformatf("row%0d_done", r), 32'(last_ndone), 32'(tbl[r].exp_done));
            chk($sformatf("row%0d_err", r), 32'(last_nerr), 32'(tbl[r].exp_err));
            for (int i = 0; i < got_q.size() && i < 4; i++)
                chk($sformatf("row%0d_rd%0d", r, i), 32'(got_q[i]), 32'(tbl[r].exp_rd[31-8*i -: 8]));
        end

        // Reset in the middle of a write burst: only the bytes before it land.
        hs = '{8'hA0, 8'h03, 8'h00, 8'h00, 8'h40, 8'hC1, 8'hC2};
        foreach (hs[i]) drive(1'b0, hs[i]);
        reset = 1'b1;
        drive(1'b0, 8'hC3);
        chk("rst_mid_wr", 32'({xfer_done, data_oe, dqs_oe, cmd_err}), 32'd0);
        reset = 1'b0;
        drive(1'b1, 8'h00);
        ref_mem[8'h40] = 8'hC1;
        ref_mem[8'h41] = 8'hC2;
        pl.delete();
        op("after_wr_rst", 8'h20, 8'h03, 32'h40, pl, -1);

        // Reset during RDATA; ncs stays low so the next byte must decode as a fresh command.
        hs = '{8'h20, 8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00};
        foreach (hs[i]) drive(1'b0, hs[i]);
        chk("pre_rst_rd", 32'({data_oe, dqs_oe, data_o}), 32'({2'b11, ref_mem[8'h11]}));
        reset = 1'b1;
        drive(1'b0, 8'h00);
        chk("rst_mid_rd", 32'({data_oe, dqs_oe, xfer_done, cmd_err, data_o}), 32'd0);
        reset = 1'b0;
        op("rd_after_rst", 8'h20, 8'h01, 32'h12, pl, -1);

        for (int it = 0; it < 40; it++) begin
            int          r;
            int          cut;
            logic [7:0]  c;
            logic [7:0]  l;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            l = 8'($urandom_range(0, 15));
            a = $urandom;
            pl.delete();
            for (int i = 0; i < 16; i++) pl.push_back(8'($urandom));
            if (r <= 3) begin
                cut = (r == 3) ? int'($urandom_range(0, int'(l))) : -1;
                op("rnd_wr", 8'hA0, l, a, pl, cut);
            end else if (r <= 7) begin
                op("rnd_rd", 8'h20, l, a, pl, -1);
            end else if (r == 8) begin
                do c = 8'($urandom); while (c == 8'hA0 || c == 8'h20 || c == 8'h05);
                op("rnd_bad", c, l, a, pl, -1);
            end else begin
                op("rnd_status", 8'h05, 8'($urandom_range(0, 3)), a, pl, -1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
